// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encodings, data-port
// access encodings and the default console address.
package memory_arbiter_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_MEM_I   = 3'd1;
    localparam logic [2:0] ST_MEM_D   = 3'd2;
    localparam logic [2:0] ST_CONSOLE = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam logic [31:0] CONSOLE_ADDRESS_DEFAULT = 32'h1000_0000;

endpackage

// File: rtl/memory_arbiter_console_fifo.sv
// Console character FIFO: power-of-two depth, one push and one pop per cycle,
// a push is refused whenever the FIFO is full.
module console_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // Depth is a power of two, so the count MSB alone marks full.
    assign full    = count_q[AW];
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop) count_d = count_q + CNT_ONE;
        else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter of instruction fetch and data load/store onto one memory
// port. Define MEMORY_ARBITER_CONSOLE_EN to add the console sink at CONSOLE_ADDRESS.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter logic [31:0] CONSOLE_ADDRESS = CONSOLE_ADDRESS_DEFAULT,
    parameter int unsigned CONSOLE_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_data,
    output logic        instr_ready,
    input  logic        data_enable,
    input  logic        data_state,
    input  logic [31:0] data_address,
    input  logic [3:0]  data_frame_mask,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ready,
    output logic        mem_request,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_frame_mask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef MEMORY_ARBITER_CONSOLE_EN
    ,
    output logic        console_valid,
    output logic [7:0]  console_char,
    input  logic        console_ready
`endif
);

    logic [2:0]  state_q, state_d;
    logic        last_data_q, last_data_d;
    logic        grant_data_q, grant_data_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] instr_data_q, instr_data_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        pick_data;

`ifdef MEMORY_ARBITER_CONSOLE_EN
    localparam int unsigned CW = $clog2(CONSOLE_DEPTH) + 1;
    logic          fifo_push, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    console_fifo #(
        .DEPTH(CONSOLE_DEPTH)
    ) u_console_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (wdata_q[7:0]),
        .pop       (console_valid && console_ready),
        .head      (console_char),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign console_valid = !fifo_empty;
    assign fifo_push     = (state_q == ST_CONSOLE) && !fifo_full;
`else
    logic unused_cfg;
    assign unused_cfg = ^CONSOLE_ADDRESS ^ CONSOLE_DEPTH[0];
`endif

    // Data wins a tie only when instruction was granted last.
    assign pick_data = data_enable && (!instr_enable || !last_data_q);

    always_comb begin
        state_d      = state_q;
        last_data_d  = last_data_q;
        grant_data_d = grant_data_q;
        addr_d       = addr_q;
        write_d      = write_q;
        mask_d       = mask_q;
        wdata_d      = wdata_q;
        instr_data_d = instr_data_q;
        data_rdata_d = data_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_enable && !pick_data) begin
                    state_d      = ST_MEM_I;
                    last_data_d  = 1'b0;
                    grant_data_d = 1'b0;
                    addr_d       = instr_address;
                    write_d      = 1'b0;
                    mask_d       = 4'b1111;
                    wdata_d      = '0;
                end else if (pick_data) begin
                    state_d      = ST_MEM_D;
                    last_data_d  = 1'b1;
                    grant_data_d = 1'b1;
                    addr_d       = data_address;
                    write_d      = (data_state == WRITE);
                    mask_d       = data_frame_mask;
                    wdata_d      = data_wdata;
`ifdef MEMORY_ARBITER_CONSOLE_EN
                    if (data_address == CONSOLE_ADDRESS) begin
                        if (data_state == WRITE) begin
                            state_d = ST_CONSOLE;
                        end else begin
                            state_d      = ST_RESP;
                            data_rdata_d = {{(32-CW){1'b0}}, fifo_count};
                        end
                    end
`endif
                end
            end
            ST_MEM_I, ST_MEM_D: begin
                if (mem_ack) begin
                    state_d = ST_RESP;
                    if (state_q == ST_MEM_I) instr_data_d = mem_rdata;
                    else if (!write_q)       data_rdata_d = mem_rdata;
                end
            end
`ifdef MEMORY_ARBITER_CONSOLE_EN
            ST_CONSOLE: begin
                if (!fifo_full) state_d = ST_RESP;
            end
`endif
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_data_q  <= 1'b1;
            grant_data_q <= 1'b0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            mask_q       <= '0;
            wdata_q      <= '0;
            instr_data_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_data_q  <= last_data_d;
            grant_data_q <= grant_data_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            mask_q       <= mask_d;
            wdata_q      <= wdata_d;
            instr_data_q <= instr_data_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign mem_request    = (state_q == ST_MEM_I) || (state_q == ST_MEM_D);
    assign mem_write      = write_q;
    assign mem_address    = addr_q;
    assign mem_frame_mask = mask_q;
    assign mem_wdata      = wdata_q;
    assign instr_ready    = (state_q == ST_RESP) && !grant_data_q;
    assign data_ready     = (state_q == ST_RESP) && grant_data_q;
    assign instr_data     = instr_data_q;
    assign data_rdata     = data_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter with a latency-programmable
// memory responder; console scenarios run when MEMORY_ARBITER_CONSOLE_EN is defined.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam logic [31:0] CON_ADDR = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_enable = 1'b0;
    logic [31:0] instr_address = '0;
    logic [31:0] instr_data;
    logic        instr_ready;
    logic        data_enable = 1'b0;
    logic        data_state = READ;
    logic [31:0] data_address = '0;
    logic [3:0]  data_frame_mask = 4'hF;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        mem_request;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_frame_mask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
`ifdef MEMORY_ARBITER_CONSOLE_EN
    logic        console_valid;
    logic [7:0]  console_char;
    logic        console_ready = 1'b0;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          ack_lat = 1;
    int          wait_cnt = 0;
    logic        model_en = 1'b1;
    logic [31:0] rd_val = '0;

    memory_arbiter #(
        .CONSOLE_ADDRESS(CON_ADDR),
        .CONSOLE_DEPTH  (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_enable   (instr_enable),
        .instr_address  (instr_address),
        .instr_data     (instr_data),
        .instr_ready    (instr_ready),
        .data_enable    (data_enable),
        .data_state     (data_state),
        .data_address   (data_address),
        .data_frame_mask(data_frame_mask),
        .data_wdata     (data_wdata),
        .data_rdata     (data_rdata),
        .data_ready     (data_ready),
        .mem_request    (mem_request),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_frame_mask (mem_frame_mask),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack)
`ifdef MEMORY_ARBITER_CONSOLE_EN
        ,
        .console_valid  (console_valid),
        .console_char   (console_char),
        .console_ready  (console_ready)
`endif
    );

    always #5 clk = ~clk;

    // Memory responder: ack raised after ack_lat negedges of an active request.
    always @(negedge clk) begin
        if (model_en) begin
            if (!mem_request) begin
                mem_ack  <= 1'b0;
                wait_cnt <= 0;
            end else if (!mem_ack) begin
                if (wait_cnt + 1 >= ack_lat) begin
                    mem_ack   <= 1'b1;
                    mem_rdata <= rd_val;
                end
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({mem_request, mem_write, instr_ready, data_ready} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {mem_request, mem_write, instr_ready, data_ready});
        end
        n_checks++;
        if ({mem_address, mem_frame_mask, mem_wdata} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h expected 0", {mem_address, mem_frame_mask, mem_wdata});
        end
        n_checks++;
        if ({instr_data, data_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 0", {instr_data, data_rdata});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({mem_request, instr_ready, data_ready} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected 000", {mem_request, instr_ready, data_ready});
        end
    endtask

    task automatic test_instr_fetch();
        int req_cyc = 0;
        int rdy = 0;
        int bad = 0;
        ack_lat = 3;
        rd_val  = 32'h0000_0013;
        instr_enable  = 1'b1;
        instr_address = 32'h40;
        @(negedge clk);
        instr_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_request) begin
                req_cyc++;
                if (mem_address !== 32'h40 || mem_write !== 1'b0 || mem_frame_mask !== 4'hF) bad++;
            end
            if (instr_ready) begin
                rdy++;
                if (instr_data !== 32'h13) bad++;
            end
            if (data_ready) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (req_cyc != 3) begin
            n_fail++;
            $display("FAIL fetch_req_cycles: got %0d expected 3", req_cyc);
        end
        n_checks++;
        if (rdy != 1) begin
            n_fail++;
            $display("FAIL fetch_ready_pulses: got %0d expected 1", rdy);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL fetch_bus_fields: got %0d bad samples expected 0", bad);
        end
        n_checks++;
        if (instr_data !== 32'h13) begin
            n_fail++;
            $display("FAIL fetch_data_hold: got %h expected 00000013", instr_data);
        end
    endtask

    task automatic test_round_robin();
        bit order_q[$];
        int both = 0;
        apply_reset();
        ack_lat = 1;
        rd_val  = 32'h5555_AAAA;
        instr_enable    = 1'b1;
        instr_address   = 32'h80;
        data_enable     = 1'b1;
        data_state      = READ;
        data_address    = 32'h200;
        data_frame_mask = 4'hF;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (instr_ready && data_ready) both++;
            else if (instr_ready) order_q.push_back(1'b0);
            else if (data_ready) order_q.push_back(1'b1);
        end
        instr_enable = 1'b0;
        data_enable  = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (order_q.size() < 4 || both != 0) begin
            n_fail++;
            $display("FAIL rr_grant_count: got %0d grants (%0d double) expected >=4",
                     order_q.size(), both);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (order_q[k] !== k[0]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got %0s expected %0s", k,
                             order_q[k] ? "data" : "instr", k[0] ? "data" : "instr");
                end
            end
        end
    endtask

    task automatic test_data_write();
        bit got = 0;
        bit seen = 0;
        logic        w_write = 1'b0;
        logic [3:0]  w_mask = '0;
        logic [31:0] w_addr = '0;
        logic [31:0] w_data = '0;
        ack_lat = 2;
        rd_val  = 32'hCAFE_F00D;
        data_enable     = 1'b1;
        data_state      = READ;
        data_address    = 32'h104;
        data_frame_mask = 4'hF;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (data_ready) got = 1;
        end
        data_enable = 1'b0;
        n_checks++;
        if (!got || data_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL dread_rdata: got %h (ready %0d) expected cafef00d", data_rdata, got);
        end
        @(negedge clk);
        rd_val          = 32'h1234_5678;
        data_enable     = 1'b1;
        data_state      = WRITE;
        data_address    = 32'h100;
        data_frame_mask = 4'b0011;
        data_wdata      = 32'hDEAD_BEEF;
        got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (mem_request && !seen) begin
                seen    = 1;
                w_write = mem_write;
                w_mask  = mem_frame_mask;
                w_addr  = mem_address;
                w_data  = mem_wdata;
            end
            if (data_ready) got = 1;
        end
        data_enable = 1'b0;
        n_checks++;
        if (!seen || w_write !== 1'b1 || w_mask !== 4'b0011) begin
            n_fail++;
            $display("FAIL dwrite_ctrl: got write=%b mask=%b expected write=1 mask=0011",
                     w_write, w_mask);
        end
        n_checks++;
        if (w_addr !== 32'h100 || w_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL dwrite_bus: got addr=%h wdata=%h expected 00000100 deadbeef",
                     w_addr, w_data);
        end
        n_checks++;
        if (!got || data_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL dwrite_rdata_hold: got %h (ready %0d) expected cafef00d",
                     data_rdata, got);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_enable_drop();
        int rdy_t = -1;
        int next_t = -1;
        int pulses = 0;
        logic [31:0] rd_at = '0;
        ack_lat = 3;
        rd_val  = 32'h0BAD_F00D;
        data_enable     = 1'b1;
        data_state      = READ;
        data_address    = 32'h300;
        data_frame_mask = 4'hF;
        @(negedge clk);
        data_enable = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (data_ready && next_t < 0) pulses++;
            if (data_ready && rdy_t < 0) begin
                rdy_t        = i;
                rd_at        = data_rdata;
                data_enable  = 1'b1;
                data_address = 32'h304;
            end else if (rdy_t >= 0 && mem_request && next_t < 0) begin
                next_t      = i;
                data_enable = 1'b0;
            end
            @(negedge clk);
        end
        data_enable = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (pulses != 1 || rd_at !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL drop_ready: got %0d pulses rdata=%h expected 1 pulse 0badf00d",
                     pulses, rd_at);
        end
        n_checks++;
        if (rdy_t < 0 || next_t - rdy_t != 2) begin
            n_fail++;
            $display("FAIL drop_next_grant: got gap %0d expected 2", next_t - rdy_t);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        model_en = 1'b0;
        mem_ack  = 1'b0;
        data_enable  = 1'b1;
        data_state   = READ;
        data_address = 32'h400;
        @(posedge clk);
        #1;
        n_checks++;
        if (mem_request !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_granted: got %b expected 1", mem_request);
        end
        @(posedge clk);
        #2;
        reset       = 1'b1;
        data_enable = 1'b0;
        #1;
        n_checks++;
        if (mem_request !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_async_drop: got %b expected 0", mem_request);
        end
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_request || instr_ready || data_ready) bad++;
            if (i == 1) mem_ack = 1'b0;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rmid_ack_ignored: got %0d active samples expected 0", bad);
        end
        n_checks++;
        if (data_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rmid_rdata_cleared: got %h expected 0", data_rdata);
        end
        model_en = 1'b1;
    endtask

`ifdef MEMORY_ARBITER_CONSOLE_EN
    task automatic test_console();
        int done = 0;
        int mem_seen = 0;
        bit got = 0;
        logic [7:0] drained_q[$];
        apply_reset();
        console_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            data_enable  = 1'b1;
            data_state   = WRITE;
            data_address = CON_ADDR;
            data_wdata   = 32'h41 + k;
            got = 0;
            for (int i = 0; i < 8 && !got; i++) begin
                @(negedge clk);
                if (mem_request) mem_seen++;
                if (data_ready) got = 1;
            end
            if (got) begin
                done++;
                data_enable = 1'b0;
            end
        end
        n_checks++;
        if (done != 8) begin
            n_fail++;
            $display("FAIL con_fill: got %0d completed writes expected 8", done);
        end
        n_checks++;
        if (console_valid !== 1'b1 || console_char !== 8'h41) begin
            n_fail++;
            $display("FAIL con_head: got valid=%b char=%h expected 1 41", console_valid, console_char);
        end
        console_ready = 1'b1;
        @(negedge clk);
        console_ready = 1'b0;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (data_ready) got = 1;
        end
        data_enable = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL con_unstall: got no ready expected ready after pop");
        end
        @(negedge clk);
        data_enable = 1'b1;
        data_state  = READ;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (mem_request) mem_seen++;
            if (data_ready) got = 1;
        end
        data_enable = 1'b0;
        n_checks++;
        if (!got || data_rdata !== 32'd8) begin
            n_fail++;
            $display("FAIL con_count_read: got %h expected 00000008", data_rdata);
        end
        n_checks++;
        if (mem_seen != 0) begin
            n_fail++;
            $display("FAIL con_no_mem: got %0d request cycles expected 0", mem_seen);
        end
        @(negedge clk);
        console_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (console_valid) drained_q.push_back(console_char);
            @(negedge clk);
        end
        console_ready = 1'b0;
        n_checks++;
        if (drained_q.size() != 8) begin
            n_fail++;
            $display("FAIL con_drain_len: got %0d expected 8", drained_q.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                n_checks++;
                if (drained_q[j] !== 8'(8'h42 + j)) begin
                    n_fail++;
                    $display("FAIL con_drain[%0d]: got %h expected %h", j, drained_q[j], 8'h42 + j);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_instr_fetch();
        test_round_robin();
        test_data_write();
        test_enable_drop();
        test_reset_mid();
`ifdef MEMORY_ARBITER_CONSOLE_EN
        test_console();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
